// File: rtl/cpu_run_ctrl_pkg.sv
// Shared types and widths for the CPU execution controller.
package cpu_run_ctrl_pkg;

    localparam int unsigned CYCLE_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2,
        HALT = 2'd3
    } run_state_e;

endpackage

// File: rtl/run_ctrl_debounce.sv
// Step-button conditioning: 2-flop synchronizer, stability counter, debounced level
// and a single-cycle event that is high in the cycle before the level rises.
module run_ctrl_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic level,
    output logic rise
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_q1;
    logic             sync_q2;
    logic             level_q;
    logic             level_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Any sample equal to the current level restarts the stability window.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sync_q2 != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync_q2;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q1 <= btn;
            sync_q2 <= sync_q1;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;
    assign rise  = level_d & ~level_q;

endmodule

// File: rtl/cpu_run_ctrl.sv
// CPU run/step/halt controller producing a one-cycle clock enable per CPU cycle.
// Optional PC breakpoint compare is built only when CPU_RUN_CTRL_BREAKPOINT_EN is defined.
module cpu_run_ctrl
    import cpu_run_ctrl_pkg::*;
#(
    parameter int unsigned FAST_DIV        = 4,
    parameter int unsigned SLOW_DIV        = 25_000_000,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                run,
    input  logic                stepBtn,
    input  logic                fastSel,
    input  logic                clr,
    input  logic [CYCLE_W-1:0]  cycleLimit,
    input  logic [31:0]         pcIn,
    input  logic [31:0]         bpAddr,
    input  logic                bpValid,
    output logic                cpuCE,
    output logic [CYCLE_W-1:0]  cycleCnt,
    output logic [1:0]          state,
    output logic                halted
);

    localparam int unsigned DIV_MAX = (FAST_DIV > SLOW_DIV) ? FAST_DIV : SLOW_DIV;
    localparam int unsigned DIV_W   = $clog2(DIV_MAX);
    localparam logic [DIV_W-1:0] FAST_LAST = DIV_W'(FAST_DIV - 1);
    localparam logic [DIV_W-1:0] SLOW_LAST = DIV_W'(SLOW_DIV - 1);

    run_state_e         state_q;
    run_state_e         state_d;
    logic [DIV_W-1:0]   div_q;
    logic [DIV_W-1:0]   div_d;
    logic [CYCLE_W-1:0] cnt_q;
    logic [CYCLE_W-1:0] cnt_d;
    logic               ce_q;
    logic               ce_d;
    logic               fast_q;
    logic               issue;

    logic               step_evt;
    logic               step_level_unused;
    logic               bp_hit;
    logic               rate_chg;
    logic               tick;
    logic               lim_on;
    logic               lim_below;
    logic               lim_hit;
    logic [DIV_W-1:0]   div_last;

    run_ctrl_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk   (CLK),
        .rst_n (RST),
        .btn   (stepBtn),
        .level (step_level_unused),
        .rise  (step_evt)
    );

`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
    assign bp_hit = bpValid && (pcIn == bpAddr);
`else
    logic bp_unused;
    assign bp_unused = ^{bpValid, bpAddr, pcIn};
    assign bp_hit    = 1'b0;
`endif

    assign div_last  = fastSel ? FAST_LAST : SLOW_LAST;
    assign rate_chg  = fastSel != fast_q;
    // A rate change restarts the interval, so it also swallows a coincident tick.
    assign tick      = (div_q == div_last) && !rate_chg;
    assign lim_on    = cycleLimit != '0;
    assign lim_below = lim_on && (cycleLimit <= cnt_q);
    assign lim_hit   = lim_on && ((cnt_q + CYCLE_W'(1)) == cycleLimit);

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
        ce_d    = 1'b0;
        issue   = 1'b0;
        if (clr) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (lim_below) begin
                        state_d = HALT;
                    end else if (run) begin
                        state_d = RUN;
                        div_d   = '0;
                    end else if (step_evt) begin
                        state_d = STEP;
                    end
                end
                RUN: begin
                    div_d = (rate_chg || tick) ? '0 : div_q + DIV_W'(1);
                    if (lim_below) begin
                        state_d = HALT;
                    end else if (tick && bp_hit) begin
                        state_d = HALT;
                    end else if (!run) begin
                        state_d = IDLE;
                    end else if (tick) begin
                        issue = 1'b1;
                    end
                end
                STEP: begin
                    // Stay one extra cycle so the pulse issued here is seen before IDLE.
                    if (ce_q) begin
                        state_d = IDLE;
                    end else begin
                        issue = 1'b1;
                    end
                end
                HALT: begin
                    state_d = HALT;
                end
            endcase
            if (issue) begin
                ce_d  = 1'b1;
                cnt_d = cnt_q + CYCLE_W'(1);
                if (lim_hit) begin
                    state_d = HALT;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            div_q   <= '0;
            cnt_q   <= '0;
            ce_q    <= 1'b0;
            fast_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            ce_q    <= ce_d;
            fast_q  <= fastSel;
        end
    end

    assign cpuCE    = ce_q;
    assign cycleCnt = cnt_q;
    assign state    = state_q;
    assign halted   = (state_q == HALT);

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Self-checking bench for cpu_run_ctrl: randomized free-run/step/breakpoint scenarios
// compared against arithmetic expectations of CE timing and counts.
module tb_cpu_run_ctrl;

    localparam int FAST = 4;
    localparam int SLOW = 7;
    localparam int DEB  = 16;
    localparam int STEP_LAT = 2 + DEB + 1;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_STEP = 2'd2;
    localparam logic [1:0] S_HALT = 2'd3;
`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
    localparam bit BP_EN = 1'b1;
`else
    localparam bit BP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b0;
    logic        step_btn = 1'b0;
    logic        fast_sel = 1'b1;
    logic        clr = 1'b0;
    logic        bp_valid = 1'b0;
    logic [31:0] cycle_limit = '0;
    logic [31:0] pc_in = '0;
    logic [31:0] bp_addr = '0;
    logic        cpu_ce;
    logic [31:0] cycle_cnt;
    logic [1:0]  state;
    logic        halted;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_cnt = '0;

    always #5 clk = ~clk;

    cpu_run_ctrl #(
        .FAST_DIV        (FAST),
        .SLOW_DIV        (SLOW),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .CLK        (clk),
        .RST        (rst_n),
        .run        (run),
        .stepBtn    (step_btn),
        .fastSel    (fast_sel),
        .clr        (clr),
        .cycleLimit (cycle_limit),
        .pcIn       (pc_in),
        .bpAddr     (bp_addr),
        .bpValid    (bp_valid),
        .cpuCE      (cpu_ce),
        .cycleCnt   (cycle_cnt),
        .state      (state),
        .halted     (halted)
    );

    task automatic cyc1;
        @(posedge clk);
        #1;
    endtask

    task automatic do_clr;
        clr = 1'b1;
        cyc1();
        clr = 1'b0;
        exp_cnt = '0;
    endtask

    function automatic logic [31:0] pc_not_bp();
        logic [31:0] v;
        v = $urandom;
        if (v == 32'h0000_3010) v = v ^ 32'h1;
        return v;
    endfunction

    task automatic test_reset;
        rst_n = 1'b0; run = 1'b1; fast_sel = 1'b1; cycle_limit = '0;
        repeat (3) cyc1();
        n_cmp++; if (state !== S_IDLE) begin n_bad++; $display("FAIL reset_state got %0d want %0d", state, S_IDLE); end
        n_cmp++; if (cpu_ce !== 1'b0) begin n_bad++; $display("FAIL reset_ce got %b want 0", cpu_ce); end
        n_cmp++; if (cycle_cnt !== 32'd0) begin n_bad++; $display("FAIL reset_cnt got %0d want 0", cycle_cnt); end
        n_cmp++; if (halted !== 1'b0) begin n_bad++; $display("FAIL reset_halted got %b want 0", halted); end
        rst_n = 1'b1;
        cyc1();
        n_cmp++; if (state !== S_RUN) begin n_bad++; $display("FAIL reset_release_state got %0d want %0d", state, S_RUN); end
        for (int r = 2; r <= 1 + 2 * FAST; r++) begin
            cyc1();
            n_cmp++;
            if (cpu_ce !== ((r - 1) % FAST == 0)) begin
                n_bad++; $display("FAIL reset_run_ce r=%0d got %b want %b", r, cpu_ce, ((r - 1) % FAST == 0));
            end
        end
        // Asynchronous reset while the pulse is high.
        rst_n = 1'b0;
        #1;
        n_cmp++; if (cpu_ce !== 1'b0) begin n_bad++; $display("FAIL async_reset_ce got %b want 0", cpu_ce); end
        n_cmp++; if (cycle_cnt !== 32'd0) begin n_bad++; $display("FAIL async_reset_cnt got %0d want 0", cycle_cnt); end
        run = 1'b0;
        repeat (2) cyc1();
        rst_n = 1'b1;
        cyc1();
        exp_cnt = '0;
    endtask

    task automatic test_free_run_limit;
        for (int t = 0; t < 4; t++) begin
            int lim;
            int d;
            logic f;
            logic exp_ce;
            run = 1'b0; bp_valid = 1'b0;
            do_clr();
            lim = $urandom_range(1, 6);
            f = 1'($urandom_range(0, 1));
            d = f ? FAST : SLOW;
            fast_sel = f; cycle_limit = 32'(lim); run = 1'b1;
            cyc1();
            for (int r = 2; r <= 1 + (lim + 3) * d; r++) begin
                pc_in = $urandom;
                cyc1();
                exp_ce = ((r - 1) % d == 0) && ((r - 1) / d <= lim);
                n_cmp++;
                if (cpu_ce !== exp_ce) begin
                    n_bad++; $display("FAIL limit_ce t=%0d r=%0d got %b want %b", t, r, cpu_ce, exp_ce);
                end
            end
            n_cmp++; if (state !== S_HALT) begin n_bad++; $display("FAIL limit_state got %0d want %0d", state, S_HALT); end
            n_cmp++; if (halted !== 1'b1) begin n_bad++; $display("FAIL limit_halted got %b want 1", halted); end
            n_cmp++; if (cycle_cnt !== 32'(lim)) begin n_bad++; $display("FAIL limit_cnt got %0d want %0d", cycle_cnt, lim); end
            // Step presses are ignored while halted.
            step_btn = 1'b1;
            for (int r = 1; r <= STEP_LAT + 5; r++) begin
                cyc1();
                n_cmp++; if (cpu_ce !== 1'b0) begin n_bad++; $display("FAIL halt_step_ce r=%0d got %b want 0", r, cpu_ce); end
            end
            step_btn = 1'b0;
            repeat (DEB + 4) cyc1();
            n_cmp++; if (state !== S_HALT) begin n_bad++; $display("FAIL halt_hold_state got %0d want %0d", state, S_HALT); end
        end
        run = 1'b0; cycle_limit = '0;
        do_clr();
    endtask

    task automatic test_step_bounce;
        run = 1'b0; cycle_limit = '0;
        do_clr();
        for (int i = 0; i < 5; i++) begin
            step_btn = (i == 4) ? 1'b0 : 1'($urandom_range(0, 1));
            cyc1();
        end
        step_btn = 1'b1;
        for (int r = 1; r <= 40; r++) begin
            cyc1();
            n_cmp++;
            if (cpu_ce !== (r == STEP_LAT)) begin
                n_bad++; $display("FAIL step_ce r=%0d got %b want %b", r, cpu_ce, (r == STEP_LAT));
            end
            if (r == STEP_LAT) begin
                exp_cnt = exp_cnt + 1;
                n_cmp++; if (cycle_cnt !== exp_cnt) begin n_bad++; $display("FAIL step_cnt got %0d want %0d", cycle_cnt, exp_cnt); end
                n_cmp++; if (state !== S_STEP) begin n_bad++; $display("FAIL step_state got %0d want %0d", state, S_STEP); end
            end
            if (r == STEP_LAT + 1) begin
                n_cmp++; if (state !== S_IDLE) begin n_bad++; $display("FAIL step_return got %0d want %0d", state, S_IDLE); end
            end
        end
        step_btn = 1'b0;
        for (int r = 1; r <= DEB + 8; r++) begin
            cyc1();
            n_cmp++; if (cpu_ce !== 1'b0) begin n_bad++; $display("FAIL step_release_ce r=%0d got %b want 0", r, cpu_ce); end
        end
        // A limit already reached halts at once without a CE.
        cycle_limit = exp_cnt;
        cyc1();
        n_cmp++; if (state !== S_HALT) begin n_bad++; $display("FAIL below_state got %0d want %0d", state, S_HALT); end
        n_cmp++; if (cpu_ce !== 1'b0) begin n_bad++; $display("FAIL below_ce got %b want 0", cpu_ce); end
        n_cmp++; if (cycle_cnt !== exp_cnt) begin n_bad++; $display("FAIL below_cnt got %0d want %0d", cycle_cnt, exp_cnt); end
        cycle_limit = '0;
        do_clr();
        n_cmp++; if (state !== S_IDLE) begin n_bad++; $display("FAIL clr_from_halt got %0d want %0d", state, S_IDLE); end
        n_cmp++; if (cycle_cnt !== 32'd0) begin n_bad++; $display("FAIL clr_cnt got %0d want 0", cycle_cnt); end
    endtask

    task automatic test_breakpoint;
        logic exp_ce;
        run = 1'b0; cycle_limit = '0;
        do_clr();
        bp_addr = 32'h0000_3010; bp_valid = 1'b1; fast_sel = 1'b1;
        pc_in = pc_not_bp(); run = 1'b1;
        cyc1();
        for (int r = 2; r <= 1 + 2 * FAST; r++) begin
            // PC matches during a non-tick cycle first, then in the tick cycle.
            pc_in = (r == FAST + 3 || r == 1 + 2 * FAST) ? bp_addr : pc_not_bp();
            cyc1();
            exp_ce = (r == 1 + FAST) || (r == 1 + 2 * FAST && !BP_EN);
            n_cmp++;
            if (cpu_ce !== exp_ce) begin
                n_bad++; $display("FAIL bp_ce r=%0d got %b want %b", r, cpu_ce, exp_ce);
            end
        end
        exp_cnt = BP_EN ? 32'd1 : 32'd2;
        n_cmp++; if (cycle_cnt !== exp_cnt) begin n_bad++; $display("FAIL bp_cnt got %0d want %0d", cycle_cnt, exp_cnt); end
        n_cmp++;
        if (state !== (BP_EN ? S_HALT : S_RUN)) begin
            n_bad++; $display("FAIL bp_state got %0d want %0d", state, (BP_EN ? S_HALT : S_RUN));
        end
        run = 1'b0;
        cyc1();
        do_clr();
        step_btn = 1'b1;
        for (int r = 1; r <= STEP_LAT + 6; r++) begin
            cyc1();
            n_cmp++;
            if (cpu_ce !== (r == STEP_LAT)) begin
                n_bad++; $display("FAIL bp_step_ce r=%0d got %b want %b", r, cpu_ce, (r == STEP_LAT));
            end
        end
        n_cmp++; if (cycle_cnt !== 32'd1) begin n_bad++; $display("FAIL bp_step_cnt got %0d want 1", cycle_cnt); end
        step_btn = 1'b0; bp_valid = 1'b0;
        repeat (DEB + 4) cyc1();
    endtask

    task automatic test_rate_clr;
        int e;
        logic exp_ce;
        run = 1'b0; cycle_limit = '0;
        do_clr();
        fast_sel = 1'b1; run = 1'b1;
        cyc1();
        e = $urandom_range(1, FAST - 1);
        for (int r = 2; r <= e + 1 + 2 * SLOW; r++) begin
            if (r == e + 1) fast_sel = 1'b0;
            if (r == e + 1 + 2 * SLOW) clr = 1'b1;
            cyc1();
            clr = 1'b0;
            exp_ce = (r == e + 1 + SLOW);
            n_cmp++;
            if (cpu_ce !== exp_ce) begin
                n_bad++; $display("FAIL rate_ce e=%0d r=%0d got %b want %b", e, r, cpu_ce, exp_ce);
            end
            if (r == e + 1 + SLOW) begin
                n_cmp++; if (cycle_cnt !== 32'd1) begin n_bad++; $display("FAIL rate_cnt got %0d want 1", cycle_cnt); end
            end
        end
        n_cmp++; if (cycle_cnt !== 32'd0) begin n_bad++; $display("FAIL clr_tick_cnt got %0d want 0", cycle_cnt); end
        n_cmp++; if (state !== S_IDLE) begin n_bad++; $display("FAIL clr_tick_state got %0d want %0d", state, S_IDLE); end
        run = 1'b0;
        repeat (2) cyc1();
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_free_run_limit();
        test_step_bounce();
        test_breakpoint();
        test_rate_clr();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Execution controller that sequences the MIPS_R2000 core on the board. It runs from the board clock and generates a one-cycle clock-enable pulse per CPU cycle. Supported modes are free-run at a selectable rate, single-step from a push button, and halt on a cycle budget or PC breakpoint. The controller exports cycle count and state for the seg7x16 display path, replacing the simulation-only cycle counter and `$finish` limit with synthesizable hardware.

## Interface
- `FAST_DIV`, 4: board-clock cycles per CPU cycle when `fastSel`=1; ≥2.
- `SLOW_DIV`, 25_000_000: board-clock cycles per CPU cycle when `fastSel`=0; ≥2.
- `DEBOUNCE_CYCLES`, 16: stable cycles required before the step-button level is accepted.

- `CLK` in 1: board clock.
- `RST` in 1: asynchronous, active-low reset.
- `run` in 1: switch level, already synchronous; 1 = free-run requested.
- `stepBtn` in 1: raw, asynchronous push button.
- `fastSel` in 1: rate select, synchronous.
- `clr` in 1: synchronous one-cycle pulse; clears the halt and the counter.
- `cycleLimit` in 32: CE budget; 0 = unlimited.
- `pcIn` in 32: current CPU PC.
- `bpAddr` in 32: breakpoint address.
- `bpValid` in 1: breakpoint armed.
- `cpuCE` out 1: registered; one-CLK pulse enabling one CPU cycle.
- `cycleCnt` out 32: count of issued CEs.
- `state` out 2: current FSM state.
- `halted` out 1: 1 in HALT.

## Operation
- **States:** IDLE=0, RUN=1, STEP=2, HALT=3. Reset enters IDLE.
- **Reset values:** `cpuCE`=0, `cycleCnt`=0, `halted`=0, divider=0, debounced level=0.
- **Priority per cycle:** `clr` > limit/breakpoint > `run`/step.
- **`clr`:** from any state, next state is IDLE, `cycleCnt` is set to 0, and no CE is issued that cycle.
- **IDLE:**
  - `run`=1 goes to RUN, with the divider cleared.
  - A step event with `run`=0 goes to STEP.
  - Step events in RUN are ignored.
- **RUN:**
  - The divider counts 0..DIV-1, where DIV comes from the current `fastSel`. A tick occurs at DIV-1, then the divider wraps to 0.
  - Any change of `fastSel` clears the divider.
  - On a tick, `cpuCE` pulses, unless a breakpoint hits.
  - `run`=0 returns to IDLE with no further CE.
- **STEP:** issues exactly one CE, then returns to IDLE. The breakpoint is ignored so the user can step past it.
- **Limit:** when a CE is issued while `cycleLimit`≠0 and `cycleCnt`+1 == `cycleLimit`, the next state is HALT. In HALT, `cycleCnt` equals `cycleLimit`.
- **Limit below count:** if `cycleLimit`≠0 and `cycleLimit` ≤ `cycleCnt` in IDLE or RUN, go to HALT immediately with no CE.
- **HALT:** no CE; `run` and step are ignored. Only `clr` or reset leave HALT.
- **Counter:** `cycleCnt` increments on each CE and wraps modulo 2^32 when the limit is 0.
- **Step input path:** 2-flop synchronizer feeds the debouncer. The debounced level updates after `DEBOUNCE_CYCLES` consecutive equal samples. A 0→1 transition of the debounced level is one step event.

## Timing
- `cpuCE` is registered and high for exactly one CLK.
- **First CE after entering RUN:** at the DIV-th rising edge after the edge that entered RUN. CEs then repeat every DIV cycles.
- **Step:** the step event is detected at edge N. STEP is entered at N, `cpuCE`=1 during the cycle after N+1, and the FSM is back in IDLE at N+2.
- **Button latency:** from a stable press to the step event is 2 + `DEBOUNCE_CYCLES` cycles.
- **Breakpoint:** checked in the tick cycle against `pcIn`. A hit goes to HALT at that edge and suppresses the CE, so the instruction at `bpAddr` is not executed.
- **Asynchronous reset mid-pulse:** `cpuCE` drops immediately.

## Configuration
- **Macro `CPU_RUN_CTRL_BREAKPOINT_EN`.**
- **Defined:** breakpoint compare as described above.
- **Undefined:**
  - `bpAddr` and `bpValid` stay in the port list but are ignored.
  - The hit signal is a constant 0.
  - No comparator is synthesized.

## Structure
- **Package `cpu_run_ctrl_pkg`:**
  - state encodings IDLE/RUN/STEP/HALT (2 bits);
  - `CYCLE_W`=32.
- **Sub-module `run_ctrl_debounce`:** synchronizer, stable counter, debounced level and rising-edge event output. Parameterized by `DEBOUNCE_CYCLES`.
- **Divider sizing:** the divider counter width is $clog2(max(FAST_DIV,SLOW_DIV)).

## Test plan
- **Reset:** reset asserted with `run`=1 → `state`=IDLE, `cpuCE`=0, `cycleCnt`=0. Release → RUN.
- **Free-run limit:** `FAST_DIV`=4, `fastSel`=1, `run`=1, `cycleLimit`=5 → CEs exactly 4 cycles apart. After the 5th CE, `state`=HALT, `cycleCnt`=5, and there are no further CEs while `run`=1.
- **Step with bounce:** step button bounces for 5 cycles, then holds 1 for 40 cycles → exactly one CE, 2+16+1 cycles after stable-high. `cycleCnt` 0→1, then IDLE.
- **Breakpoint:** `CPU_RUN_CTRL_BREAKPOINT_EN` defined, `bpAddr`=0x00003010, `pcIn` set to 0x00003010 at a tick → HALT with no CE that tick. Then `clr` then step → one CE issued at the same PC. With the macro undefined, the same tick issues a CE.
- **Rate and clr:** `fastSel` toggled mid-interval → divider restarts, and the next CE comes DIV cycles after the toggle. `clr` in the same cycle as a tick → no CE, `cycleCnt`=0, IDLE.
